// File: rtl/arb_pkg.sv
// arb_pkg: shared widths and state encoding for the round-robin arbiter
package arb_pkg;
    localparam int NUM_REQ = 8;
    localparam int IDX_W = 3;
    typedef enum logic {IDLE, BUSY} arb_state_t;
endpackage

// File: rtl/decoder3x8.sv
// decoder3x8: 3-to-8 one-hot decoder
module decoder3x8 (
    input  logic [2:0] a,
    output logic [7:0] y
);
    assign y = 8'(1) << a;
endmodule

// File: rtl/rr_arbiter8.sv
// rr_arbiter8: eight-way round-robin arbiter with hold limit and one dead cycle between owners
module rr_arbiter8 import arb_pkg::*; #(
    parameter int HOLD_MAX = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_valid,
    output logic               timeout
);
    localparam int CW = HOLD_MAX > 0 ? $clog2(HOLD_MAX + 1) : 1;
    localparam logic [CW-1:0] HLIM = CW'(HOLD_MAX > 0 ? HOLD_MAX - 1 : 0);
    arb_state_t state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d, idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic timeout_q, timeout_d;
    logic [NUM_REQ-1:0] dec_y;
    logic hit, rel;
    // Rotate so ptr lands at bit 0, take the lowest set bit, then undo the rotation.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r, input logic [IDX_W-1:0] p);
        logic [2*NUM_REQ-1:0] dbl;
        logic [IDX_W-1:0] off;
        dbl = {r, r} >> p;
        off = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (dbl[i]) off = IDX_W'(i);
        return p + off;
    endfunction
    always_comb begin
        hit = (HOLD_MAX != 0) && (cnt_q == HLIM);
        rel = done || !req[idx_q] || hit;
        state_d = state_q;
        ptr_d = ptr_q;
        idx_d = idx_q;
        cnt_d = cnt_q;
        timeout_d = 1'b0;
        if (state_q == IDLE) begin
            if (|req) begin
                idx_d = rr_pick(req, ptr_q);
                cnt_d = '0;
                state_d = BUSY;
            end
        end else if (rel) begin
            state_d = IDLE;
            ptr_d = idx_q + 1'b1;
            timeout_d = hit && !done && req[idx_q];
        end else begin
            cnt_d = cnt_q + CW'(cnt_q != '1);
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q <= '0;
            idx_q <= '0;
            cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q <= ptr_d;
            idx_q <= idx_d;
            cnt_q <= cnt_d;
            timeout_q <= timeout_d;
        end
    end
    decoder3x8 u_dec (.a(idx_q), .y(dec_y));
    assign gnt_valid = state_q == BUSY;
    assign gnt = dec_y & {NUM_REQ{gnt_valid}};
    assign gnt_idx = idx_q;
    assign timeout = timeout_q;
endmodule
